iot_multi_monitor: RTL

- Multi-channel successor to the single active-IoT-device counter.
- Tracks N_CH independent device groups. Each group has its own up/down active-device counter, with wrap or saturate selectable by parameter.
- Maintains an exact aggregate total across all groups and raises a hysteresis alarm on that total.
- Sits between the device event decoders and the system status/register block. Also provides a registered indexed read port for the CPU-side register map.

---
 rtl/iot_multi_monitor_pkg.sv | 47 ++++
 rtl/iot_multi_monitor_chan_counter.sv | 79 +++++++
 rtl/iot_multi_monitor.sv | 111 +++++++++++
 3 files changed

// File: rtl/iot_multi_monitor_pkg.sv
// rtl/iot_multi_monitor_pkg.sv - shared constants and helpers for the multi-channel IoT monitor
//
// Package iot_mon_pkg:
//   DIR_UP / DIR_DOWN  : encodings of the on_off direction input
//   clog2(n)           : ceiling log2, used for index and total widths
//   sat_or_wrap_step() : one up/down step of a counter with top value max_val,
//                        either wrapping around or clamping at the limits
package iot_mon_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // value and max_val are carried at 32 bits so any counter width up to 32
    // can share this helper; the caller truncates the result back down.
    function automatic logic [31:0] sat_or_wrap_step(
        input logic [31:0] value,
        input logic [31:0] max_val,
        input logic        up,
        input logic        saturate
    );
        logic [31:0] r;
        if (up == DIR_DOWN) begin
            if (value == 32'd0) begin
                r = saturate ? 32'd0 : max_val;
            end else begin
                r = value - 32'd1;
            end
        end else begin
            if (value == max_val) begin
                r = saturate ? max_val : 32'd0;
            end else begin
                r = value + 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iot_multi_monitor_chan_counter.sv
// rtl/iot_multi_monitor_chan_counter.sv - one channel of the IoT monitor: up/down counter with wrap or saturate
//
// Optional feature macro: IOT_MONITOR_LIMIT_FLAGS_EN (adds the sticky limit_flag output)
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : synchronous clear to 0 (highest priority)
//   change      : step strobe; 0 holds the counter
//   on_off      : step direction (DIR_UP / DIR_DOWN)
//   count       : counter register
//   delta       : signed difference between the value loaded at the next edge and count
//   limit_flag  : sticky flag, set on a wrap or a blocked step, cleared by clr (macro only)
module iot_chan_counter
    import iot_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    change,
    input  logic                    on_off,
    output logic [WIDTH-1:0]        count,
`ifdef IOT_MONITOR_LIMIT_FLAGS_EN
    output logic signed [WIDTH:0]   delta,
    output logic                    limit_flag
`else
    output logic signed [WIDTH:0]   delta
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        stepped = WIDTH'(sat_or_wrap_step(32'(count), 32'(MAX_VAL),
                                          on_off == DIR_UP, SATURATE != 0));
        if (clr) begin
            count_next = '0;
        end else if (change) begin
            count_next = stepped;
        end else begin
            count_next = count;
        end
        // One extra bit so the full range -(2^WIDTH-1) .. +(2^WIDTH-1) fits,
        // which is what a clear from max or a wrap produces.
        delta = $signed({1'b0, count_next}) - $signed({1'b0, count});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef IOT_MONITOR_LIMIT_FLAGS_EN
    // A step attempted at the limit in the step direction is a wrap
    // (SATURATE=0) or a blocked step (SATURATE=1); both raise the flag.
    logic at_limit;
    assign at_limit = (on_off == DIR_UP) ? (count == MAX_VAL) : (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit_flag <= 1'b0;
        end else if (clr) begin
            limit_flag <= 1'b0;
        end else if (change && at_limit) begin
            limit_flag <= 1'b1;
        end
    end
`else
`endif

endmodule

// File: rtl/iot_multi_monitor.sv
// rtl/iot_multi_monitor.sv - multi-channel active-IoT-device counter with exact total and hysteresis alarm
//
// Optional feature macro: IOT_MONITOR_LIMIT_FLAGS_EN (adds limit_flag[N_CH])
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   change       : per-channel step strobe
//   on_off       : per-channel direction, 1 = up, 0 = down
//   clr          : per-channel synchronous clear
//   rd_sel       : channel index for the registered read port
//   rd_count     : counter[rd_sel] as it stood before the last edge (0 if rd_sel >= N_CH)
//   counts_flat  : all counters, channel i at [i*WIDTH +: WIDTH]
//   total        : exact sum of all counters, same edge as the counters
//   alarm        : set at total >= ALARM_HI, cleared at total <= ALARM_LO, else held
//   limit_flag   : per-channel sticky wrap/blocked-step flags (macro only)
module iot_multi_monitor
    import iot_mon_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int WIDTH    = 8,
    parameter  int SATURATE = 0,
    parameter  int ALARM_HI = 16,
    parameter  int ALARM_LO = 12,
    localparam int SEL_W    = clog2(N_CH),
    localparam int TOT_W    = WIDTH + clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         change,
    input  logic [N_CH-1:0]         on_off,
    input  logic [N_CH-1:0]         clr,
    input  logic [SEL_W-1:0]        rd_sel,
    output logic [WIDTH-1:0]        rd_count,
    output logic [N_CH*WIDTH-1:0]   counts_flat,
    output logic [TOT_W-1:0]        total,
`ifdef IOT_MONITOR_LIMIT_FLAGS_EN
    output logic                    alarm,
    output logic [N_CH-1:0]         limit_flag
`else
    output logic                    alarm
`endif
);

    logic [WIDTH-1:0]        counts [N_CH];
    logic signed [WIDTH:0]   delta  [N_CH];
    logic [TOT_W-1:0]        total_next;
    logic                    alarm_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        iot_chan_counter #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr[i]),
            .change     (change[i]),
            .on_off     (on_off[i]),
            .count      (counts[i]),
`ifdef IOT_MONITOR_LIMIT_FLAGS_EN
            .delta      (delta[i]),
            .limit_flag (limit_flag[i])
`else
            .delta      (delta[i])
`endif
        );

        assign counts_flat[i*WIDTH +: WIDTH] = counts[i];
    end

    // The true sum always fits in TOT_W bits, so accumulating the
    // sign-extended deltas modulo 2^TOT_W lands on the exact value.
    always_comb begin
        total_next = total;
        for (int i = 0; i < N_CH; i++) begin
            total_next = total_next + TOT_W'(delta[i]);
        end
    end

    always_comb begin
        alarm_next = alarm;
        if (32'(total_next) >= ALARM_HI) begin
            alarm_next = 1'b1;
        end else if (32'(total_next) <= ALARM_LO) begin
            alarm_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total <= '0;
            alarm <= 1'b0;
        end else begin
            total <= total_next;
            alarm <= alarm_next;
        end
    end

    // Registered read: samples the pre-edge counter, so an rd_sel change
    // shows up one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
        end else if (32'(rd_sel) < N_CH) begin
            rd_count <= counts[rd_sel];
        end else begin
            rd_count <= '0;
        end
    end

endmodule
